// File: rtl/riscv_fetch_stage.sv
// riscv_fetch_stage: PC owner and IF/ID register with 1-cycle imem latency, stall hold buffer and redirect flush
module riscv_fetch_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_gnt,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    output logic        id_valid,
    output logic [31:0] id_pc,
    output logic [31:0] id_pc_plus4,
    output logic [31:0] id_inst
);
    logic [31:0] pc, resp_pc, hold_pc, hold_inst;
    logic        outstanding, hold_full, accept, resp;
    assign imem_req  = !rst && !stall && !redirect && !hold_full;
    assign imem_addr = pc;
    assign accept    = imem_req && imem_gnt;
    assign resp      = imem_rvalid && outstanding;
    always_ff @(posedge clk) begin
        if (rst) begin
            pc          <= RESET_PC;
            outstanding <= 1'b0;
            resp_pc     <= '0;
            hold_full   <= 1'b0;
            hold_pc     <= '0;
            hold_inst   <= '0;
            id_valid    <= 1'b0;
            id_pc       <= '0;
            id_pc_plus4 <= '0;
            id_inst     <= NOP_INST;
        end else begin
            outstanding <= accept;
            if (accept) begin
                pc      <= pc + 32'd4;
                resp_pc <= pc;
            end
            if (redirect) begin
                pc        <= redirect_pc & 32'hFFFF_FFFC;
                id_valid  <= 1'b0;
                id_inst   <= NOP_INST;
                hold_full <= 1'b0;
            end else if (stall) begin
                if (resp) begin
                    hold_full <= 1'b1;
                    hold_pc   <= resp_pc;
                    hold_inst <= imem_rdata;
                end
            end else if (hold_full) begin
                id_valid    <= 1'b1;
                id_pc       <= hold_pc;
                id_pc_plus4 <= hold_pc + 32'd4;
                id_inst     <= hold_inst;
                hold_full   <= 1'b0;
            end else if (resp) begin
                id_valid    <= 1'b1;
                id_pc       <= resp_pc;
                id_pc_plus4 <= resp_pc + 32'd4;
                id_inst     <= imem_rdata;
            end else begin
                id_valid <= 1'b0;
                id_inst  <= NOP_INST;
            end
        end
    end
endmodule

// File: tb/tb_riscv_fetch_stage.sv
// tb_riscv_fetch_stage: random and directed stimulus against a queue-based fetch model
module tb_riscv_fetch_stage;
    localparam logic [31:0] RST_PC = 32'hFFFF_FFFC;
    localparam logic [31:0] NOP    = 32'h0000_0013;
    localparam logic [31:0] KEY    = 32'hA5A5_0000;
    logic        clk = 1'b0;
    logic        rst, stall, redirect, imem_gnt, imem_rvalid;
    logic [31:0] redirect_pc, imem_rdata;
    logic        imem_req, id_valid;
    logic [31:0] imem_addr, id_pc, id_pc_plus4, id_inst;
    int          total = 0;
    int          bad = 0;
    logic [31:0] m_pc, m_ipc, m_ipc4, m_inst, mem_a;
    logic [31:0] m_fly[$];
    logic [31:0] m_hold[$];
    logic        m_v, mem_v;

    riscv_fetch_stage #(.RESET_PC(RST_PC), .NOP_INST(NOP)) dut (
        .clk(clk), .rst(rst), .stall(stall), .redirect(redirect), .redirect_pc(redirect_pc),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_gnt(imem_gnt),
        .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
        .id_valid(id_valid), .id_pc(id_pc), .id_pc_plus4(id_pc_plus4), .id_inst(id_inst)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_pc = RST_PC;
        m_fly.delete();
        m_hold.delete();
        m_v = 1'b0;
        m_ipc = '0;
        m_ipc4 = '0;
        m_inst = NOP;
    endtask

    task automatic load_id(input logic [31:0] a);
        m_v = 1'b1;
        m_ipc = a;
        m_ipc4 = a + 32'd4;
        m_inst = a ^ KEY;
    endtask

    task automatic cyc(input bit r, input bit s, input bit d, input bit g, input bit sp, input logic [31:0] rp);
        logic        req, got;
        logic [31:0] ra;
        @(negedge clk);
        rst = r;
        stall = s;
        redirect = d;
        redirect_pc = rp;
        imem_gnt = g;
        imem_rvalid = mem_v | sp;
        imem_rdata = mem_v ? (mem_a ^ KEY) : $urandom;
        #1;
        req = !r && !s && !d && m_hold.size() == 0;
        check("imem_req", {31'd0, imem_req}, {31'd0, req});
        check("imem_addr", imem_addr, m_pc);
        check("id_valid", {31'd0, id_valid}, {31'd0, m_v});
        check("id_pc", id_pc, m_ipc);
        check("id_pc_plus4", id_pc_plus4, m_ipc4);
        check("id_inst", id_inst, m_inst);
        got = imem_rvalid && m_fly.size() > 0;
        ra = got ? m_fly[0] : 32'd0;
        mem_v = req && g;
        mem_a = m_pc;
        if (r) model_reset();
        else begin
            m_fly.delete();
            if (req && g) begin
                m_fly.push_back(m_pc);
                m_pc = m_pc + 32'd4;
            end
            if (d) begin
                m_pc = rp & ~32'd3;
                m_v = 1'b0;
                m_inst = NOP;
                m_hold.delete();
            end else if (s) begin
                if (got) m_hold.push_back(ra);
            end else if (m_hold.size() > 0) load_id(m_hold.pop_front());
            else if (got) load_id(ra);
            else begin
                m_v = 1'b0;
                m_inst = NOP;
            end
        end
    endtask

    initial begin
        rst = 1'b1; stall = 1'b0; redirect = 1'b0; redirect_pc = '0;
        imem_gnt = 1'b0; imem_rvalid = 1'b0; imem_rdata = '0;
        mem_v = 1'b0; mem_a = '0;
        model_reset();
        repeat (2) @(posedge clk);
        cyc(1, 0, 0, 1, 0, 0);
        repeat (6) cyc(0, 0, 0, 1, 0, 0);
        repeat (3) cyc(0, 1, 0, 1, 0, 0);
        repeat (4) cyc(0, 0, 0, 1, 0, 0);
        cyc(0, 0, 1, 1, 0, 32'h0000_0103);
        repeat (4) cyc(0, 0, 0, 1, 0, 0);
        cyc(0, 1, 0, 1, 0, 0);
        cyc(0, 1, 1, 1, 0, 32'h0000_0202);
        cyc(0, 1, 0, 1, 0, 0);
        repeat (3) cyc(0, 0, 0, 1, 0, 0);
        repeat (2) cyc(0, 0, 0, 0, 0, 0);
        repeat (3) cyc(0, 0, 0, 1, 0, 0);
        cyc(1, 0, 0, 1, 0, 0);
        cyc(0, 0, 0, 1, 1, 0);
        repeat (3) cyc(0, 0, 0, 1, 0, 0);
        repeat (3000)
            cyc($urandom_range(0, 49) == 0, $urandom_range(0, 4) == 0, $urandom_range(0, 11) == 0,
                $urandom_range(0, 3) != 0, $urandom_range(0, 9) == 0, $urandom);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/riscv_fetch_stage.md
Name: riscv_fetch_stage

Overview:
- Instruction-fetch front end that sits directly upstream of the decode stage inside RISCV_pipeline.
- Owns the PC, issues requests to a synchronous instruction memory and absorbs the one-cycle read latency.
- Produces the IF/ID pipeline register (valid, pc, pc+4, instruction) that decode consumes.
- Honours stall from the hazard unit and redirect (branch/jump/flush) from EX.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- NOP_INST, 32'h0000_0013, instruction driven on id_inst when no valid instruction is present (addi x0,x0,0).

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  synchronous, active-high reset.
- stall  input  1  hazard unit: hold the IF/ID register and stop issuing fetches.
- redirect  input  1  EX: flush and restart fetch at redirect_pc.
- redirect_pc  input  32  new fetch address; bits [1:0] ignored (forced 0).
- imem_req  output  1  fetch request.
- imem_addr  output  32  fetch address, word aligned.
- imem_gnt  input  1  memory accepts request this cycle.
- imem_rvalid  input  1  read data valid; exactly 1 cycle after a grant.
- imem_rdata  input  32  instruction word.
- id_valid  output  1  IF/ID holds a real instruction.
- id_pc  output  32  PC of id_inst.
- id_pc_plus4  output  32  id_pc + 4, modulo 2^32.
- id_inst  output  32  instruction to decode.

Behaviour:
- Interface: one clock (clk); reset rst is synchronous and active-high.
- Reset (rst=1 at a clk edge) sets:
  - pc=RESET_PC; outstanding=0; hold buffer empty.
  - id_valid=0, id_pc=0, id_pc_plus4=0, id_inst=NOP_INST.
- imem_req is combinational = !rst & !stall & !redirect & !hold_full.
  - imem_req=0 while rst=1.
  - imem_addr = pc at all times.
- Accept happens when imem_req & imem_gnt:
  - pc <= pc+4 (wraps 32'hFFFF_FFFC -> 0).
  - outstanding <= 1, and the accepted address is saved as resp_pc.
  - outstanding clears the next cycle. At most one request is in flight.
- Response handling (imem_rvalid=1 while outstanding=1):
  - stall=0: IF/ID <= {1, resp_pc, resp_pc+4, imem_rdata}.
  - stall=1: response goes to the 1-entry hold buffer (hold_full=1); IF/ID is unchanged.
  - rvalid with outstanding=0 is ignored.
- IF/ID update when stall=0 and redirect=0, priority order:
  1. Hold buffer full: load from buffer and clear it. No fetch is issued that cycle, because hold_full was still 1.
  2. Else, a valid response: load the response.
  3. Else, insert a bubble: id_valid<=0, id_inst<=NOP_INST; id_pc/id_pc_plus4 hold.
- stall=1 and redirect=0:
  - IF/ID holds all fields.
  - No new request is issued.
  - An in-flight response is still captured into the hold buffer.
- redirect=1 has highest priority and overrides stall:
  - pc <= {redirect_pc[31:2],2'b00}.
  - id_valid<=0, id_inst<=NOP_INST.
  - Hold buffer cleared; any response arriving this cycle is discarded.
  - No request is issued this cycle.
  - First fetch at the new PC happens the following cycle (if stall=0).
- Steady state (no stall, gnt=1 every cycle): one instruction per cycle into IF/ID, 1-cycle fetch latency.
  - First valid instruction after reset release: id_valid=1 two edges after the first imem_req.
- Reset mid-operation: rst overrides everything. The in-flight response is dropped because outstanding is cleared.
- gnt=0: pc and imem_addr hold, and imem_req stays asserted (if permitted) until granted.

Test Plan:
- Reset, then imem returns rdata=addr^32'hA5A5_0000 with gnt=1:
  - imem_addr sequence is 0,4,8,…
  - id_pc 0,4,8 on consecutive cycles with id_valid=1; id_inst=32'hA5A5_0000 for pc 0.
  - id_pc_plus4 = id_pc+4.
- Stall asserted for 3 cycles one cycle after the grant of pc=8:
  - IF/ID holds pc=4 throughout.
  - pc=8 response goes to the hold buffer, and imem_req=0 during the stall.
  - On release: id_pc=8, then bubble (id_valid=0), then id_pc=12; no instruction lost or duplicated.
- redirect=1, redirect_pc=32'h0000_0103, in the same cycle as rvalid for pc=16:
  - pc=16 is discarded; id_valid=0, id_inst=0x00000013.
  - Next imem_addr=0x100; id_pc=0x100 two cycles later.
- redirect during stall=1:
  - Flush occurs: id_valid=0, buffer cleared.
  - Fetch at redirect_pc starts when stall drops.
- gnt held 0 for 2 cycles at pc=0x20:
  - imem_addr stays 0x20 with imem_req=1.
  - id_valid=0 bubbles; fetch resumes at 0x20 when granted.
- RESET_PC=32'hFFFF_FFFC:
  - First fetch 0xFFFF_FFFC, next 0x0000_0000.
  - id_pc_plus4=0 for the first instruction.
- Reset asserted while a response is outstanding: outputs return to reset values and the response is ignored.
